// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, tag/wait-counter widths and FSM state encoding for mac_dispatch
package mac_pkg;
  localparam int DEF_A_BITWIDTH = 8;
  localparam int DEF_OUT_BITWIDTH = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, RESULT, RECOVER} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: count-based synchronous FIFO (CLK, RST, push/wdata in, pop/rdata out, full/empty flags)
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
)(
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wr, rd;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge CLK) if (wr) mem[wp] <= wdata;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/mac_dispatch.sv
// mac_dispatch: buffers tagged operand triples, issues them to a MAC with timeout, returns tagged results (IN_* push, MAC_* request/response, OUT_* result)
module mac_dispatch
  import mac_pkg::*;
#(
  parameter int A_BITWIDTH = DEF_A_BITWIDTH,
  parameter int OUT_BITWIDTH = DEF_OUT_BITWIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [A_BITWIDTH-1:0]   IN_A,
  input  logic [A_BITWIDTH-1:0]   IN_B,
  input  logic [A_BITWIDTH-1:0]   IN_C,
  output logic                    MAC_EN,
  output logic [A_BITWIDTH-1:0]   MAC_A,
  output logic [A_BITWIDTH-1:0]   MAC_B,
  output logic [A_BITWIDTH-1:0]   MAC_C,
  input  logic [OUT_BITWIDTH-1:0] MAC_MOUT,
  input  logic                    MAC_DONE,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [OUT_BITWIDTH-1:0] OUT_DATA,
  output logic [TAG_W-1:0]        OUT_TAG,
  output logic                    OUT_ERR
);
  localparam int FW = TAG_W + 3 * A_BITWIDTH;
  state_t state, state_nx;
  logic [TAG_W-1:0] tag_cnt, op_tag;
  logic [CNT_W-1:0] wait_cnt;
  logic [FW-1:0] head;
  logic full, empty, pop, tmo, fin;
  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .push(IN_VALID),
    .wdata({tag_cnt, IN_A, IN_B, IN_C}),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign IN_READY = !full;
  assign pop = state == IDLE && !empty;
  assign tmo = wait_cnt >= CNT_W'(TIMEOUT_CYCLES);
  assign fin = state == ISSUE && (MAC_DONE || tmo);
  always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : ISSUE;
      ISSUE:   state_nx = (MAC_DONE || tmo) ? RESULT : ISSUE;
      RESULT:  state_nx = OUT_READY ? RECOVER : RESULT;
      RECOVER: state_nx = MAC_DONE ? RECOVER : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    MAC_EN = state == ISSUE;
    OUT_VALID = state == RESULT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_cnt <= '0;
      op_tag <= '0;
      wait_cnt <= '0;
      MAC_A <= '0;
      MAC_B <= '0;
      MAC_C <= '0;
      OUT_DATA <= '0;
      OUT_TAG <= '0;
      OUT_ERR <= 1'b0;
    end else begin
      if (IN_VALID && !full) tag_cnt <= tag_cnt + TAG_W'(1);
      if (pop) begin
        {op_tag, MAC_A, MAC_B, MAC_C} <= head;
        wait_cnt <= CNT_W'(1);
      end else if (state == ISSUE && !fin) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (fin) begin
        OUT_DATA <= MAC_DONE ? MAC_MOUT : '0;
        OUT_ERR <= !MAC_DONE;
        OUT_TAG <= op_tag;
      end
    end
  end
endmodule
